invaders_game_ctrl: RTL

- Frame-synchronous game sequencer for the VGA sprite subsystem.
- Per pixel, detects missile/alien overlap and records pending kills. At each frame boundary it commits them to a registered alive mask, so the display stays stable within a frame.
- Runs the ATTRACT/PLAY/WIN/LOSE state machine and drives the layer-select code the VGA top uses to choose background, sprite or end-screen pixels.

---
 rtl/invaders_pkg.sv | 31 +++
 rtl/invaders_hit_tracker.sv | 96 +++++++++
 rtl/invaders_game_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/invaders_pkg.sv
// ============================================================================
// Module   : invaders_pkg
// Brief    : Shared types and default sizes for the invaders game sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package invaders_pkg;

  localparam int NUM_ALIENS_DEF     = 15;
  localparam int ALIENS_PER_GRP_DEF = 5;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_WIN     = 2'd2,
    ST_LOSE    = 2'd3
  } game_state_e;

  typedef enum logic [2:0] {
    LAYER_BG     = 3'd0,
    LAYER_PLAYER = 3'd1,
    LAYER_MISSLE = 3'd2,
    LAYER_ALIEN  = 3'd3,
    LAYER_WIN    = 3'd4,
    LAYER_LOSE   = 3'd5
  } layer_sel_e;

endpackage

`default_nettype wire

// File: rtl/invaders_hit_tracker.sv
// ============================================================================
// Module   : invaders_hit_tracker
// Brief    : Pending-kill capture and frame-boundary commit into the alive
//            mask; optional kill score when INVADERS_SCORE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module invaders_hit_tracker
  import invaders_pkg::*;
#(
  parameter int NUM_ALIENS = NUM_ALIENS_DEF,
  parameter int SCORE_W    = 12
) (
  input  logic                  vga_clk_i,
  input  logic                  vga_rst_i,
  input  logic                  rearm_i,
  input  logic                  capture_i,
  input  logic                  commit_i,
  input  logic [NUM_ALIENS-1:0] alien_px_i,
  output logic [NUM_ALIENS-1:0] alive_o,
  output logic                  alive_zero_o,
  output logic                  kill_o,
  output logic [SCORE_W-1:0]    score_o
);

  logic [NUM_ALIENS-1:0] r_alive;
  logic [NUM_ALIENS-1:0] r_pend;
  logic                  r_kill;
  logic [NUM_ALIENS-1:0] w_killed;
  logic [NUM_ALIENS-1:0] w_alive_commit;

  assign w_killed       = r_alive & r_pend;
  assign w_alive_commit = r_alive & ~r_pend;
  assign alive_zero_o   = (w_alive_commit == '0);

  // A hit seen on the commit cycle is carried into the fresh pending mask.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      r_alive <= '1;
      r_pend  <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_kill <= 1'b0;
      if (rearm_i) begin
        r_alive <= '1;
        r_pend  <= '0;
      end else if (commit_i) begin
        r_alive <= w_alive_commit;
        r_pend  <= capture_i ? (alien_px_i & w_alive_commit) : '0;
        r_kill  <= |w_killed;
      end else if (capture_i) begin
        r_pend  <= r_pend | (alien_px_i & r_alive);
      end
    end
  end

  assign alive_o = r_alive;
  assign kill_o  = r_kill;

`ifdef INVADERS_SCORE_EN
  localparam int CNT_W = $clog2(NUM_ALIENS + 1);
  localparam int SUM_W = SCORE_W + 1;

  function automatic logic [CNT_W-1:0] f_popcount(input logic [NUM_ALIENS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [SCORE_W-1:0] r_score;
  logic [SUM_W-1:0]   w_sum;

  assign w_sum = {1'b0, r_score} + SUM_W'(f_popcount(w_killed));

  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      r_score <= '0;
    end else if (rearm_i) begin
      r_score <= '0;
    end else if (commit_i) begin
      r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
    end
  end

  assign score_o = r_score;
`else
  assign score_o = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/invaders_game_ctrl.sv
// ============================================================================
// Module   : invaders_game_ctrl
// Brief    : Frame-synchronous ATTRACT/PLAY/WIN/LOSE sequencer and VGA layer
//            select. Optional score counter: INVADERS_SCORE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module invaders_game_ctrl
  import invaders_pkg::*;
#(
  parameter int NUM_ALIENS     = NUM_ALIENS_DEF,
  parameter int ALIENS_PER_GRP = ALIENS_PER_GRP_DEF,
  parameter int HOLD_FRAMES    = 180,
  parameter int SCORE_W        = 12
) (
  input  logic                  vga_clk_i,
  input  logic                  vga_rst_i,
  input  logic                  frame_start_i,
  input  logic                  video_on_i,
  input  logic                  start_i,
  input  logic [NUM_ALIENS-1:0] alien_px_i,
  input  logic                  missle_px_i,
  input  logic                  player_px_i,
  input  logic                  landed_i,
  output logic [NUM_ALIENS-1:0] alive_o,
  output logic [1:0]            state_o,
  output logic [2:0]            layer_sel_o,
  output logic [1:0]            alien_grp_o,
  output logic                  kill_o,
  output logic [SCORE_W-1:0]    score_o
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  game_state_e           r_state;
  game_state_e           w_state_next;
  logic                  r_land;
  logic [HOLD_W-1:0]     r_hold;
  logic [NUM_ALIENS-1:0] w_alive;
  logic [NUM_ALIENS-1:0] w_live_px;
  logic                  w_alive_zero;
  logic                  w_in_play;
  logic                  w_rearm;
  logic                  w_commit;
  logic                  w_capture;
  logic                  w_holding;
  logic                  w_hold_done;
  layer_sel_e            w_layer;
  logic [1:0]            w_first_grp;
  logic [1:0]            w_grp;

  assign w_in_play   = (r_state == ST_PLAY);
  assign w_rearm     = (r_state == ST_ATTRACT);
  assign w_holding   = (r_state == ST_WIN) || (r_state == ST_LOSE);
  assign w_commit    = w_in_play && frame_start_i;
  assign w_capture   = w_in_play && video_on_i && missle_px_i;
  assign w_hold_done = w_holding && frame_start_i && (r_hold == HOLD_W'(HOLD_FRAMES - 1));

  invaders_hit_tracker #(
    .NUM_ALIENS (NUM_ALIENS),
    .SCORE_W    (SCORE_W)
  ) u_hit_tracker (
    .vga_clk_i    (vga_clk_i),
    .vga_rst_i    (vga_rst_i),
    .rearm_i      (w_rearm),
    .capture_i    (w_capture),
    .commit_i     (w_commit),
    .alien_px_i   (alien_px_i),
    .alive_o      (w_alive),
    .alive_zero_o (w_alive_zero),
    .kill_o       (kill_o),
    .score_o      (score_o)
  );

  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      r_state <= ST_ATTRACT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // WIN outranks LOSE when the last alien dies in the frame it lands.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ATTRACT: if (start_i) w_state_next = ST_PLAY;
      ST_PLAY: begin
        if (w_commit) begin
          if (w_alive_zero)  w_state_next = ST_WIN;
          else if (r_land)   w_state_next = ST_LOSE;
        end
      end
      ST_WIN, ST_LOSE: if (w_hold_done) w_state_next = ST_ATTRACT;
      default: w_state_next = ST_ATTRACT;
    endcase
  end

  // A landing seen on the commit cycle belongs to the following frame.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      r_land <= 1'b0;
    end else if (w_rearm) begin
      r_land <= 1'b0;
    end else if (w_commit) begin
      r_land <= landed_i;
    end else if (w_in_play && landed_i) begin
      r_land <= 1'b1;
    end
  end

  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      r_hold <= '0;
    end else if (!w_holding) begin
      r_hold <= '0;
    end else if (frame_start_i) begin
      r_hold <= w_hold_done ? '0 : r_hold + 1'b1;
    end
  end

  assign w_live_px = alien_px_i & w_alive;

  always_comb begin
    w_first_grp = '0;
    for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
      if (w_live_px[i]) w_first_grp = 2'(i / ALIENS_PER_GRP);
    end
  end

  always_comb begin
    w_layer = LAYER_BG;
    w_grp   = '0;
    if (r_state == ST_WIN) begin
      w_layer = LAYER_WIN;
    end else if (r_state == ST_LOSE) begin
      w_layer = LAYER_LOSE;
    end else if (|w_live_px) begin
      w_layer = LAYER_ALIEN;
      w_grp   = w_first_grp;
    end else if (missle_px_i) begin
      w_layer = LAYER_MISSLE;
    end else if (player_px_i) begin
      w_layer = LAYER_PLAYER;
    end
  end

  assign alive_o     = w_alive;
  assign state_o     = r_state;
  assign layer_sel_o = w_layer;
  assign alien_grp_o = w_grp;

endmodule

`default_nettype wire
